// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: one shared ALU, one unified memory port with req/ready handshake.
// Define MIPS_MC_PERF_EN to add the cyc_cnt/instret counters. ADDR_W is assumed to be <= 32.
module mips_multicycle #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       NREGS    = 32
) (
  input  logic              clock,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              err
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instret
`endif
);

  localparam int unsigned RW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL
  } alu_op_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       imm_q;
  logic [31:0]       alu_q;
  logic [31:0]       mdr_q;
  logic              err_q;
  logic [31:0]       regs_q [NREGS];

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [RW-1:0] wb_idx;
  logic [31:0]   wb_val;
  logic          legal;
  logic          is_branch;
  logic          is_ctrl;
  logic          br_taken;
  logic [31:0]   pc_ext;
  logic [ADDR_W-1:0] jump_tgt;

  alu_op_t     alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign shamt     = ir_q[10:6];
  assign rs        = ir_q[21 +: RW];
  assign rt        = ir_q[16 +: RW];
  assign rd        = ir_q[11 +: RW];
  assign pc_ext    = 32'(pc_q);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_ctrl   = is_branch || (opcode == OP_J);
  assign br_taken  = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign wb_idx    = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_val    = (opcode == OP_LW) ? mdr_q : alu_q;

  if (ADDR_W > 28) begin : g_jump_wide
    assign jump_tgt = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
  end else begin : g_jump_narrow
    logic [27:0] jump_low;
    assign jump_low = {ir_q[25:0], 2'b00};
    assign jump_tgt = jump_low[ADDR_W-1:0];
  end

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // The ALU also produces PC+4 in FETCH and the branch target in EXEC.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_a = pc_ext;
        alu_b = 32'd4;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              F_SUB:   alu_op = ALU_SUB;
              F_AND:   alu_op = ALU_AND;
              F_OR:    alu_op = ALU_OR;
              F_SLT:   alu_op = ALU_SLT;
              F_SLL:   alu_op = ALU_SLL;
              default: alu_op = ALU_ADD;
            endcase
          end
          OP_ADDI, OP_LW, OP_SW: alu_b = imm_q;
          OP_BEQ, OP_BNE: begin
            alu_a = pc_ext;
            alu_b = {imm_q[29:0], 2'b00};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLL: alu_res = alu_b << shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        if (is_ctrl) begin
          state_d = S_FETCH;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_d = (alu_res[1:0] != 2'b00) ? S_ERR : S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM:    if (mem_ready) state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_RST;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_SW);
        mem_addr = alu_q[ADDR_W-1:0];
        if (opcode == OP_SW) mem_wdata = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= alu_res[ADDR_W-1:0];
          end
        end
        S_DECODE: begin
          a_q   <= regs_q[rs];
          b_q   <= regs_q[rt];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (opcode == OP_J) begin
            pc_q <= jump_tgt;
          end else if (is_branch && br_taken) begin
            pc_q <= alu_res[ADDR_W-1:0];
          end
        end
        S_MEM: begin
          if (mem_ready && (opcode == OP_LW)) mdr_q <= mem_rdata;
        end
        S_WB: begin
          if (wb_idx != '0) regs_q[wb_idx] <= wb_val;
        end
        default: ;
      endcase
      if (state_d == S_ERR) err_q <= 1'b1;
    end
  end

  assign pc_out = pc_q;
  assign err    = err_q;

`ifdef MIPS_MC_PERF_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (state_q == S_WB)
               || ((state_q == S_MEM) && mem_ready && (opcode == OP_SW))
               || ((state_q == S_EXEC) && is_ctrl);

  always_ff @(posedge clock) begin
    if (Reset) begin
      cyc_cnt_q <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q != S_RST) && (state_q != S_ERR)) cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs in a word memory model with per-address stalls.
`timescale 1ns/1ps
module tb_mips_multicycle;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc_out;
  logic        err;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] instret;
`endif

  logic [31:0] mem [64];
  logic        ld_en    = 1'b0;
  logic        ld_clear = 1'b0;
  logic [5:0]  ld_idx   = '0;
  logic [31:0] ld_data  = '0;
  logic [31:0] ld_fill  = '0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int unsigned stall_n = 0;
  int unsigned req_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0), .NREGS(32)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .err       (err)
`ifdef MIPS_MC_PERF_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .instret   (instret)
`endif
  );

  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ready = mem_req && (req_cnt >= ((mem_addr == stall_addr) ? stall_n : 32'd0));

  always @(posedge clock) begin
    if (ld_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= ld_fill;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    if (Reset || !mem_req || mem_ready) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic begin_load(input logic [31:0] fill);
    @(negedge clock);
    Reset = 1'b1;
    ld_clear = 1'b1;
    ld_fill = fill;
    @(negedge clock);
    ld_clear = 1'b0;
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] d);
    @(negedge clock);
    ld_en = 1'b1;
    ld_idx = idx[5:0];
    ld_data = d;
  endtask

  // Returns at the negedge where the core sits in RST with Reset just released.
  task automatic start();
    @(negedge clock);
    ld_en = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req_we got %b want 00", {mem_req, mem_we}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 00000000", mem_wdata); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", pc_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
`ifdef MIPS_MC_PERF_EN
    checks++; if ({cyc_cnt, instret} !== 64'h0) begin errors++; $display("FAIL reset_perf got %h/%h want 0/0", cyc_cnt, instret); end
`endif
  endtask

  task automatic test_alu_seq();
    stall_addr = 32'hFFFF_FFFF;
    begin_load(32'h0);
    poke(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(1, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    poke(2, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    poke(3, enc_i(6'h2B, 5'd0, 5'd3, 16'h0080));
    poke(4, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    start();
    step(5);
    checks++; if ({pc_out, mem_req, mem_addr} !== {32'h4, 1'b1, 32'h4}) begin errors++; $display("FAIL t1_first_addi pc %h req %b addr %h want 4/1/4", pc_out, mem_req, mem_addr); end
    step(8);
    checks++; if (pc_out !== 32'hC) begin errors++; $display("FAIL t1_pc12 got %h want 0000000c", pc_out); end
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'hC}) begin errors++; $display("FAIL t1_fetch12 req %b addr %h want 1/0000000c", mem_req, mem_addr); end
`ifdef MIPS_MC_PERF_EN
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL t1_instret got %0d want 3", instret); end
    checks++; if (cyc_cnt !== 32'd12) begin errors++; $display("FAIL t1_cyc_cnt got %0d want 12", cyc_cnt); end
`endif
    step(4);
    checks++; if (mem[32] !== 32'd2) begin errors++; $display("FAIL t1_r3 got %h want 00000002", mem[32]); end
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL t1_pc_after_sw got %h want 00000010", pc_out); end
    step(3);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL t3_beq_loop1 got %h want 00000010", pc_out); end
    step(1);
    checks++; if (pc_out !== 32'h14) begin errors++; $display("FAIL t3_beq_inc got %h want 00000014", pc_out); end
    step(2);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL t3_beq_loop2 got %h want 00000010", pc_out); end
  endtask

  task automatic test_mem_stall();
    stall_addr = 32'h8;
    stall_n = 3;
    begin_load(32'h0);
    poke(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(1, {6'h02, 26'd16});
    poke(2, 32'hDEAD_BEEF);
    poke(16, enc_i(6'h2B, 5'd0, 5'd1, 16'h0008));
    poke(17, enc_i(6'h23, 5'd0, 5'd4, 16'h0008));
    poke(18, enc_i(6'h2B, 5'd0, 5'd4, 16'h0084));
    poke(19, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    start();
    step(11);
    for (int k = 0; k < 4; k++) begin
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h8, 32'h5}) begin
        errors++; $display("FAIL t2_sw_hold%0d req %b we %b addr %h wdata %h want 1/1/8/5", k, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (k < 3) step(1);
    end
    checks++; if (mem[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t2_sw_early got %h want deadbeef", mem[2]); end
    step(1);
    checks++; if (mem[2] !== 32'h5) begin errors++; $display("FAIL t2_sw_data got %h want 00000005", mem[2]); end
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h44}) begin errors++; $display("FAIL t2_after_sw req %b we %b addr %h want 1/0/44", mem_req, mem_we, mem_addr); end
    step(3);
    for (int k = 0; k < 4; k++) begin
      checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h8}) begin
        errors++; $display("FAIL t2_lw_hold%0d req %b we %b addr %h want 1/0/8", k, mem_req, mem_we, mem_addr);
      end
      step(1);
    end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t2_lw_wb req %b want 0", mem_req); end
    step(1);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h48}) begin errors++; $display("FAIL t2_after_lw req %b addr %h want 1/48", mem_req, mem_addr); end
    step(4);
    checks++; if (mem[33] !== 32'h5) begin errors++; $display("FAIL t2_r4 got %h want 00000005", mem[33]); end
    stall_n = 0;
  endtask

  task automatic test_branch();
    stall_addr = 32'hFFFF_FFFF;
    begin_load(32'h0);
    poke(0, {6'h02, 26'd4});
    poke(4, enc_i(6'h05, 5'd0, 5'd0, 16'd5));
    poke(5, enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    poke(6, enc_i(6'h05, 5'd1, 5'd0, 16'd2));
    poke(9, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    start();
    step(4);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL t3_jump got %h want 00000010", pc_out); end
    step(3);
    checks++; if ({pc_out, mem_addr} !== {32'h14, 32'h14}) begin errors++; $display("FAIL t3_bne_nt pc %h addr %h want 14/14", pc_out, mem_addr); end
    step(7);
    checks++; if ({pc_out, mem_addr} !== {32'h24, 32'h24}) begin errors++; $display("FAIL t3_bne_taken pc %h addr %h want 24/24", pc_out, mem_addr); end
`ifdef MIPS_MC_PERF_EN
    checks++; if (instret !== 32'd4) begin errors++; $display("FAIL t3_instret got %0d want 4", instret); end
`endif
    step(3);
    checks++; if (pc_out !== 32'h24) begin errors++; $display("FAIL t3_beq_loop got %h want 00000024", pc_out); end
  endtask

  task automatic test_rtype();
    logic [31:0] prog [17];
    logic [31:0] exp_v [7];
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);
    prog[3]  = enc_r(5'd0, 5'd1, 5'd6, 5'd4, 6'h00);
    prog[4]  = enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h20);
    prog[5]  = enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h22);
    prog[6]  = enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h24);
    prog[7]  = enc_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h25);
    prog[8]  = enc_r(5'd1, 5'd2, 5'd10, 5'd0, 6'h2A);
    prog[9]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0080);
    prog[10] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0084);
    prog[11] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0088);
    prog[12] = enc_i(6'h2B, 5'd0, 5'd7, 16'h008C);
    prog[13] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0090);
    prog[14] = enc_i(6'h2B, 5'd0, 5'd9, 16'h0094);
    prog[15] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0098);
    prog[16] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    exp_v[0] = 32'h1; exp_v[1] = 32'h50; exp_v[2] = 32'h0; exp_v[3] = 32'h8;
    exp_v[4] = 32'h5; exp_v[5] = 32'hFFFF_FFFD; exp_v[6] = 32'h0;
    stall_addr = 32'hFFFF_FFFF;
    begin_load(32'hA5A5_A5A5);
    for (int i = 0; i < 17; i++) poke(i, prog[i]);
    start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (pc_out == 32'h44) break;
    end
    checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL t4_timeout pc %h want 00000044", pc_out); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (mem[32 + i] !== exp_v[i]) begin errors++; $display("FAIL t4_word%0d got %h want %h", i, mem[32 + i], exp_v[i]); end
    end
  endtask

  task automatic test_err();
    stall_addr = 32'hFFFF_FFFF;
    begin_load(32'h0);
    poke(0, 32'hFC00_0000);
    start();
    step(2);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_op_early err %b want 0", err); end
    step(1);
    checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL t5_op_err err %b req %b want 1/0", err, mem_req); end
    step(5);
    checks++; if ({err, mem_req, pc_out} !== {2'b10, 32'h4}) begin errors++; $display("FAIL t5_op_hold err %b req %b pc %h want 1/0/4", err, mem_req, pc_out); end

    begin_load(32'h0);
    poke(0, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
    start();
    step(3);
    checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL t5_funct_err err %b req %b want 1/0", err, mem_req); end

    begin_load(32'h0);
    poke(0, enc_i(6'h23, 5'd0, 5'd1, 16'h0006));
    start();
    step(3);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_lw_early err %b want 0", err); end
    step(1);
    checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL t5_lw_err err %b req %b want 1/0", err, mem_req); end
    step(3);
    checks++; if ({err, mem_req, pc_out} !== {2'b10, 32'h4}) begin errors++; $display("FAIL t5_lw_hold err %b req %b pc %h want 1/0/4", err, mem_req, pc_out); end
`ifdef MIPS_MC_PERF_EN
    checks++; if (cyc_cnt !== 32'd3) begin errors++; $display("FAIL t5_cyc_frozen got %0d want 3", cyc_cnt); end
`endif
    @(negedge clock); Reset = 1'b1;
    @(negedge clock); Reset = 1'b0;
    checks++; if ({err, mem_req, pc_out} !== {2'b00, 32'h0}) begin errors++; $display("FAIL t5_reset err %b req %b pc %h want 0/0/0", err, mem_req, pc_out); end
    step(1);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL t5_refetch req %b addr %h want 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_reset_stall();
    stall_addr = 32'h4;
    stall_n = 1000;
    begin_load(32'h0);
    poke(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    poke(1, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
    start();
    step(7);
    checks++; if ({mem_req, mem_addr, pc_out} !== {1'b1, 32'h4, 32'h4}) begin errors++; $display("FAIL t6_stalled req %b addr %h pc %h want 1/4/4", mem_req, mem_addr, pc_out); end
    Reset = 1'b1;
    step(1);
    checks++; if ({mem_req, pc_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL t6_abandon req %b pc %h want 0/0", mem_req, pc_out); end
    Reset = 1'b0;
    stall_n = 0;
    step(1);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL t6_restart req %b addr %h want 1/0", mem_req, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_mem_stall();
    test_branch();
    test_rtype();
    test_err();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
